sticky_fault_latch: RTL
=======================

Name: sticky_fault_latch

Overview:
Multi-bit sticky fault/status latch, successor to the simple latch-high cell.
- Per-bit enable mask and software write-1-to-clear.
- Records which bits fired first and counts new latch events (saturating).
- Drives a registered interrupt.
- Sits between shim fault sources (overcurrent, FIFO over/underflow, trigger errors) and the AXI status/interrupt logic.

Parameters:
WIDTH, 32, number of fault bits.
CNT_WIDTH, 16, width of saturating new-event counter.
TS_WIDTH, 32, width of free-running timestamp counter (used only with optional feature).

Ports:
clk  input  1  system clock; all logic on rising edge.
resetn  input  1  asynchronous, active-low reset.
din  input  WIDTH  raw fault pulses/levels, synchronous to clk.
mask  input  WIDTH  per-bit enable; 1 = bit may latch.
clr  input  WIDTH  write-1-to-clear strobe for latched bits.
clr_first  input  1  pulse: release first-fault record and zero event counter.
dout  output  WIDTH  latched status, including same-cycle pass-through.
first_bits  output  WIDTH  masked din bits present on the first-fault cycle.
first_valid  output  1  first-fault record held.
event_cnt  output  CNT_WIDTH  saturating count of new-latch events.
first_ts  output  TS_WIDTH  timestamp of the first fault (see Optional Feature).
irq  output  1  registered; high while any bit is latched.

Behaviour:
Reset (asynchronous, resetn low): latch, first_bits, first_valid, event_cnt, first_ts, irq and the timestamp counter all go to 0. dout = act during reset.

Definitions:
- act = din & mask.
- new = act & ~latch.

Latch register (set wins over clear on the same bit in the same cycle):
- latch_next = (latch & ~clr) | act.
- dout = latch | act (combinational, zero latency, as before).
- Clearing a bit whose din is still asserted leaves it set.

First-fault capture:
- If act != 0 and (first_valid == 0 or clr_first == 1): first_bits <= act, first_valid <= 1.
- Else if clr_first: first_bits <= 0, first_valid <= 0.
- Otherwise both hold. Later faults never overwrite the record.
- clr does not affect first_bits or first_valid.

Event counter:
- Increments by 1 on each cycle where new != 0. Multiple new bits in one cycle count once.
- Saturates at all-ones and holds there; no wrap.
- clr_first sets it to 0. If an event occurs in the same cycle, it is set to 1 instead.

Interrupt:
- irq <= |latch_next, so irq rises one cycle after the first act.
- irq falls one cycle after the last bit is cleared.

Mask changes:
- Take effect the same cycle.
- Do not clear already-latched bits.
- A masked bit does not pass through to dout.

No handshake: all strobes are single-cycle. A strobe held high acts every cycle.

Optional Feature:
Macro: STICKY_FAULT_LATCH_TIMESTAMP_EN.
- Defined: a free-running TS_WIDTH counter increments every cycle from 0 after reset and wraps at all-ones to 0. On each first-fault capture (including the re-capture under clr_first), first_ts <= counter value in that cycle. clr_first without capture sets first_ts to 0.
- Undefined: no counter is instantiated; first_ts is tied to 0. The port list is unchanged.

Decomposition:
- Package lcb_fault_pkg: default WIDTH/CNT_WIDTH/TS_WIDTH localparams; a function for the saturating increment.
- Sub-module sat_counter (WIDTH param, inc, clr, count out; clr+inc = 1), used for event_cnt.
- Latch and first-fault logic stay in the top module.

Test Plan:
1. Reset/pass-through (WIDTH=8, mask=0xFF): din=0x04 for 1 cycle → dout=0x04 that cycle and stays 0x04 after din=0; irq=1 from the next cycle; first_bits=0x04; first_valid=1; event_cnt=1.
2. Set-vs-clear: latch=0x04; clr=0x04 with din=0x04 in the same cycle → dout stays 0x04. Then clr=0x04 alone → dout=0x00 and irq=0 one cycle later.
3. First-fault hold: din=0x01, then din=0x80 → first_bits=0x01, dout=0x81, event_cnt=2. Then clr_first with din=0x10 in the same cycle → first_bits=0x10, event_cnt=1.
4. Mask: mask=0xF0, din=0x0F → dout=0, irq=0, event_cnt=0. Set mask=0xFF with latch=0x80 → 0x80 retained.
5. Saturation (CNT_WIDTH=2): produce 5 distinct new-bit events → event_cnt reads 1, 2, 3, 3, 3.
6. Timestamp (macro defined): first fault 100 cycles after reset release → first_ts=100. A second fault does not change it. Async reset asserted mid-run zeros all outputs immediately.

Source files
------------

// File: rtl/sticky_fault_latch_pkg.sv
// ---------------------------------------------------------------------------
// lcb_fault_pkg
// Shared defaults and helpers for the sticky fault latch slice.
//   DEF_WIDTH     : default number of fault bits
//   DEF_CNT_WIDTH : default width of the saturating new-event counter
//   DEF_TS_WIDTH  : default width of the free-running timestamp counter
//   sat_inc_en()  : gates an increment request so a full counter holds
// ---------------------------------------------------------------------------
package lcb_fault_pkg;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_CNT_WIDTH = 16;
    localparam int unsigned DEF_TS_WIDTH  = 32;

    // Saturating increment helper: width-agnostic by taking the reduction-AND
    // of the counter, so the caller adds the returned bit without wrapping.
    function automatic logic sat_inc_en(input logic inc, input logic all_ones);
        return inc & ~all_ones;
    endfunction

endpackage : lcb_fault_pkg

// File: rtl/sticky_fault_latch_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. Clear and increment in the
// same cycle load 1 (the clear discards history, the event still counts).
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   inc_i   : increment by one (held at all-ones once reached)
//   clr_i   : synchronous clear
//   count_o : current count
// ---------------------------------------------------------------------------
module sat_counter
    import lcb_fault_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_CNT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? WIDTH'(1) : '0;
        end else begin
            count_d = count_q + WIDTH'(sat_inc_en(inc_i, &count_q));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter

// File: rtl/sticky_fault_latch.sv
// ---------------------------------------------------------------------------
// sticky_fault_latch
// Multi-bit sticky fault/status latch with per-bit mask, write-1-to-clear,
// first-fault record, saturating new-event counter and registered interrupt.
// Optional first-fault timestamp enabled by macro STICKY_FAULT_LATCH_TIMESTAMP_EN.
//   clk         : system clock, rising edge
//   resetn      : asynchronous active-low reset
//   din         : raw fault pulses/levels
//   mask        : per-bit enable (1 = may latch)
//   clr         : write-1-to-clear strobe for latched bits
//   clr_first   : release first-fault record and zero event counter
//   dout        : latched status OR'd with same-cycle masked din
//   first_bits  : masked din on the first-fault cycle
//   first_valid : first-fault record held
//   event_cnt   : saturating count of cycles with newly latched bits
//   first_ts    : timestamp of first fault (0 when feature disabled)
//   irq         : registered, high while any bit is latched
// ---------------------------------------------------------------------------
module sticky_fault_latch
    import lcb_fault_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int unsigned TS_WIDTH  = DEF_TS_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [WIDTH-1:0]     din,
    input  logic [WIDTH-1:0]     mask,
    input  logic [WIDTH-1:0]     clr,
    input  logic                 clr_first,
    output logic [WIDTH-1:0]     dout,
    output logic [WIDTH-1:0]     first_bits,
    output logic                 first_valid,
    output logic [CNT_WIDTH-1:0] event_cnt,
    output logic [TS_WIDTH-1:0]  first_ts,
    output logic                 irq
);

    logic [WIDTH-1:0] act;
    logic [WIDTH-1:0] new_bits;
    logic [WIDTH-1:0] latch_q,      latch_d;
    logic [WIDTH-1:0] first_bits_q, first_bits_d;
    logic             first_valid_q, first_valid_d;
    logic             irq_q;
    logic             capture;

    assign act      = din & mask;
    assign new_bits = act & ~latch_q;
    assign dout     = latch_q | act;

    always_comb begin
        // Set is OR'd in after the clear so a still-asserted source wins.
        latch_d       = (latch_q & ~clr) | act;
        // clr_first with a fault in the same cycle re-arms and captures at once.
        capture       = (|act) && (!first_valid_q || clr_first);
        first_bits_d  = first_bits_q;
        first_valid_d = first_valid_q;
        if (capture) begin
            first_bits_d  = act;
            first_valid_d = 1'b1;
        end else if (clr_first) begin
            first_bits_d  = '0;
            first_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            latch_q       <= '0;
            first_bits_q  <= '0;
            first_valid_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            latch_q       <= latch_d;
            first_bits_q  <= first_bits_d;
            first_valid_q <= first_valid_d;
            irq_q         <= |latch_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_event_cnt (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .inc_i   (|new_bits),
        .clr_i   (clr_first),
        .count_o (event_cnt)
    );

`ifdef STICKY_FAULT_LATCH_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] first_ts_q, first_ts_d;

    always_comb begin
        first_ts_d = first_ts_q;
        if (capture) begin
            first_ts_d = ts_q;
        end else if (clr_first) begin
            first_ts_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts_q       <= '0;
            first_ts_q <= '0;
        end else begin
            ts_q       <= ts_q + TS_WIDTH'(1);
            first_ts_q <= first_ts_d;
        end
    end

    assign first_ts = first_ts_q;
`else
    assign first_ts = '0;
`endif

    assign first_bits  = first_bits_q;
    assign first_valid = first_valid_q;
    assign irq         = irq_q;

endmodule : sticky_fault_latch
